// File: rtl/siw_addrgen_bram_8.sv
// Strided burst address generator / access sequencer for one siw_memory_bram_8 port.
// Optional abort/beat-count feature enabled by defining SIW_ADDRGEN_ABORT_EN.
module siw_addrgen_bram_8 #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              siw_addrgen_bram_8_clk,
    input  logic              siw_addrgen_bram_8_reset_n,
`ifdef SIW_ADDRGEN_ABORT_EN
    input  logic              siw_addrgen_bram_8_abort,
    output logic [ADDR_W:0]   siw_addrgen_bram_8_beats,
`endif
    input  logic              siw_addrgen_bram_8_start,
    input  logic              siw_addrgen_bram_8_dir,
    input  logic [ADDR_W-1:0] siw_addrgen_bram_8_base,
    input  logic [ADDR_W-1:0] siw_addrgen_bram_8_stride,
    input  logic [ADDR_W:0]   siw_addrgen_bram_8_count,
    input  logic [1:0]        siw_addrgen_bram_8_conf,
    output logic              siw_addrgen_bram_8_busy,
    output logic              siw_addrgen_bram_8_done,
    input  logic [DATA_W-1:0] siw_addrgen_bram_8_wdata,
    input  logic              siw_addrgen_bram_8_wvalid,
    output logic              siw_addrgen_bram_8_wready,
    output logic [DATA_W-1:0] siw_addrgen_bram_8_rdata,
    output logic              siw_addrgen_bram_8_rvalid,
    output logic              siw_addrgen_bram_8_mem_enable,
    output logic              siw_addrgen_bram_8_mem_write_en,
    output logic              siw_addrgen_bram_8_mem_init,
    output logic [ADDR_W-1:0] siw_addrgen_bram_8_mem_addr,
    output logic [DATA_W-1:0] siw_addrgen_bram_8_mem_wdata,
    output logic [1:0]        siw_addrgen_bram_8_mem_conf,
    input  logic [DATA_W-1:0] siw_addrgen_bram_8_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    logic                dir_r;
    logic [ADDR_W-1:0]   stride_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W:0]     count_r;
    logic [ADDR_W:0]     beat_cnt;
    logic [1:0]          conf_r;
    logic [7:0]          drain_cnt;
    logic [7:0]          wait_val;
    logic                busy_r;
    logic                done_r;
    logic                init_r;

    logic                abort_req;
    logic                run;
    logic                rd_issue;
    logic                wr_issue;
    logic                issue;
    logic                last_beat;

    // write delay line stages, stage N holds a beat accepted N cycles ago
    logic                wr_vld_p1, wr_vld_p2, wr_vld_p3;
    logic [ADDR_W-1:0]   wr_addr_p1, wr_addr_p2, wr_addr_p3;
    logic [DATA_W-1:0]   wr_data_p1, wr_data_p2, wr_data_p3;

    logic                tap_vld;
    logic [ADDR_W-1:0]   tap_addr;
    logic [DATA_W-1:0]   tap_data;

    logic [RD_LAT-1:0]   rd_pipe;
    logic [ADDR_W-1:0]   addr_hold;
    logic [DATA_W-1:0]   data_hold;

`ifdef SIW_ADDRGEN_ABORT_EN
    assign abort_req                = siw_addrgen_bram_8_abort;
    assign siw_addrgen_bram_8_beats = beat_cnt;
`else
    assign abort_req = 1'b0;
`endif

    assign run       = (state == RUN);
    assign rd_issue  = run && !dir_r && !abort_req;
    assign siw_addrgen_bram_8_wready = run && dir_r && !abort_req;
    assign wr_issue  = siw_addrgen_bram_8_wready && siw_addrgen_bram_8_wvalid;
    assign issue     = rd_issue || wr_issue;
    assign last_beat = issue && (beat_cnt == count_r - 1'b1);

    // writes drain until the delayed strobe lands; reads until data returns
    assign wait_val  = dir_r ? {6'd0, conf_r} : 8'(RD_LAT);

    always_ff @(posedge siw_addrgen_bram_8_clk or negedge siw_addrgen_bram_8_reset_n) begin
        if (!siw_addrgen_bram_8_reset_n) begin
            state     <= IDLE;
            dir_r     <= 1'b0;
            stride_r  <= '0;
            addr_r    <= '0;
            count_r   <= '0;
            beat_cnt  <= '0;
            conf_r    <= 2'd0;
            drain_cnt <= 8'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            init_r    <= 1'b0;
        end else begin
            init_r <= 1'b0;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (siw_addrgen_bram_8_start) begin
                        dir_r    <= siw_addrgen_bram_8_dir;
                        stride_r <= siw_addrgen_bram_8_stride;
                        addr_r   <= siw_addrgen_bram_8_base;
                        count_r  <= siw_addrgen_bram_8_count;
                        conf_r   <= siw_addrgen_bram_8_conf;
                        beat_cnt <= '0;
                        busy_r   <= 1'b1;
                        init_r   <= 1'b1;
                        if (siw_addrgen_bram_8_count == '0) begin
                            state     <= DRAIN;
                            drain_cnt <= 8'd1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_r   <= addr_r + stride_r;
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (last_beat || abort_req) begin
                        state     <= DRAIN;
                        drain_cnt <= wait_val;
                        done_r    <= (wait_val == 8'd0);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 8'd0) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 8'd1;
                        done_r    <= (drain_cnt == 8'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // stage p1..p3: write delay line, shifts every cycle so it empties during DRAIN
    always_ff @(posedge siw_addrgen_bram_8_clk or negedge siw_addrgen_bram_8_reset_n) begin
        if (!siw_addrgen_bram_8_reset_n) begin
            wr_vld_p1  <= 1'b0;
            wr_vld_p2  <= 1'b0;
            wr_vld_p3  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_addr_p2 <= '0;
            wr_addr_p3 <= '0;
            wr_data_p1 <= '0;
            wr_data_p2 <= '0;
            wr_data_p3 <= '0;
        end else begin
            wr_vld_p1  <= wr_issue;
            wr_vld_p2  <= wr_vld_p1;
            wr_vld_p3  <= wr_vld_p2;
            wr_addr_p1 <= addr_r;
            wr_addr_p2 <= wr_addr_p1;
            wr_addr_p3 <= wr_addr_p2;
            wr_data_p1 <= siw_addrgen_bram_8_wdata;
            wr_data_p2 <= wr_data_p1;
            wr_data_p3 <= wr_data_p2;
        end
    end

    always_comb begin
        tap_vld  = wr_issue;
        tap_addr = addr_r;
        tap_data = siw_addrgen_bram_8_wdata;
        case (conf_r)
            2'd1: begin
                tap_vld  = wr_vld_p1;
                tap_addr = wr_addr_p1;
                tap_data = wr_data_p1;
            end
            2'd2: begin
                tap_vld  = wr_vld_p2;
                tap_addr = wr_addr_p2;
                tap_data = wr_data_p2;
            end
            2'd3: begin
                tap_vld  = wr_vld_p3;
                tap_addr = wr_addr_p3;
                tap_data = wr_data_p3;
            end
            default: ;
        endcase
    end

    // read-valid pipeline matching the BRAM's RAM + output register latency
    always_ff @(posedge siw_addrgen_bram_8_clk or negedge siw_addrgen_bram_8_reset_n) begin
        if (!siw_addrgen_bram_8_reset_n) begin
            rd_pipe   <= '0;
            addr_hold <= '0;
            data_hold <= '0;
        end else begin
            rd_pipe[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            addr_hold <= siw_addrgen_bram_8_mem_addr;
            data_hold <= siw_addrgen_bram_8_mem_wdata;
        end
    end

    assign siw_addrgen_bram_8_mem_enable   = rd_issue || tap_vld;
    assign siw_addrgen_bram_8_mem_write_en = wr_issue;
    assign siw_addrgen_bram_8_mem_addr     = rd_issue ? addr_r : (tap_vld ? tap_addr : addr_hold);
    assign siw_addrgen_bram_8_mem_wdata    = tap_vld ? tap_data : data_hold;
    assign siw_addrgen_bram_8_mem_conf     = conf_r;
    assign siw_addrgen_bram_8_mem_init     = init_r;
    assign siw_addrgen_bram_8_busy         = busy_r;
    assign siw_addrgen_bram_8_done         = done_r;
    assign siw_addrgen_bram_8_rvalid       = rd_pipe[RD_LAT-1];
    assign siw_addrgen_bram_8_rdata        = rd_pipe[RD_LAT-1] ? siw_addrgen_bram_8_mem_rdata : '0;

endmodule

// File: tb/tb_siw_addrgen_bram_8.sv
// Bench for siw_addrgen_bram_8: behavioural BRAM, event monitor and burst-level reference model.
module tb_siw_addrgen_bram_8;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = AW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start = 1'b0, dir = 1'b0;
    logic [AW-1:0] base = '0, stride = '0;
    logic [AW:0]   count = '0;
    logic [1:0]    conf = '0;
    logic          busy, done;
    logic [DW-1:0] wdata = '0;
    logic          wvalid = 1'b0, wready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          mem_enable, mem_write_en, mem_init;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_conf;
    logic [DW-1:0] mem_rdata;
`ifdef SIW_ADDRGEN_ABORT_EN
    logic          abort = 1'b0;
    logic [AW:0]   beats;
`endif

    siw_addrgen_bram_8 dut (
        .siw_addrgen_bram_8_clk(clk),
        .siw_addrgen_bram_8_reset_n(rst_n),
`ifdef SIW_ADDRGEN_ABORT_EN
        .siw_addrgen_bram_8_abort(abort),
        .siw_addrgen_bram_8_beats(beats),
`endif
        .siw_addrgen_bram_8_start(start),
        .siw_addrgen_bram_8_dir(dir),
        .siw_addrgen_bram_8_base(base),
        .siw_addrgen_bram_8_stride(stride),
        .siw_addrgen_bram_8_count(count),
        .siw_addrgen_bram_8_conf(conf),
        .siw_addrgen_bram_8_busy(busy),
        .siw_addrgen_bram_8_done(done),
        .siw_addrgen_bram_8_wdata(wdata),
        .siw_addrgen_bram_8_wvalid(wvalid),
        .siw_addrgen_bram_8_wready(wready),
        .siw_addrgen_bram_8_rdata(rdata),
        .siw_addrgen_bram_8_rvalid(rvalid),
        .siw_addrgen_bram_8_mem_enable(mem_enable),
        .siw_addrgen_bram_8_mem_write_en(mem_write_en),
        .siw_addrgen_bram_8_mem_init(mem_init),
        .siw_addrgen_bram_8_mem_addr(mem_addr),
        .siw_addrgen_bram_8_mem_wdata(mem_wdata),
        .siw_addrgen_bram_8_mem_conf(mem_conf),
        .siw_addrgen_bram_8_mem_rdata(mem_rdata)
    );

    // Behavioural BRAM: write strobe delayed by mem_conf, 2-cycle read latency
    logic [DW-1:0] bram [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    logic          preload = 1'b0;
    logic [2:0]    we_hist = '0;
    logic          dly_we;
    logic [DW-1:0] rd1 = '0, rd2 = '0;

    always_comb begin
        dly_we = mem_write_en;
        case (mem_conf)
            2'd1: dly_we = we_hist[0];
            2'd2: dly_we = we_hist[1];
            2'd3: dly_we = we_hist[2];
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) bram[i] <= ref_mem[i];
        end else if (mem_enable && dly_we) begin
            bram[mem_addr] <= mem_wdata;
        end
        we_hist <= mem_init ? {2'b00, mem_write_en} : {we_hist[1:0], mem_write_en};
        if (mem_enable) rd1 <= bram[mem_addr];
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    // Event monitor
    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          we;
    } ev_t;
    ev_t q_en[$];
    ev_t q_rv[$];
    int  q_we[$];
    int  q_done[$];
    int  q_init[$];
    int  xfer_cyc[$];
    logic [DW-1:0] xfer_dat[$];
    logic [AW:0] done_beats = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_enable) q_en.push_back('{c: cyc, a: mem_addr, d: mem_wdata, we: mem_write_en});
            if (rvalid) q_rv.push_back('{c: cyc, a: '0, d: rdata, we: 1'b0});
            if (mem_write_en) q_we.push_back(cyc);
            if (mem_init) q_init.push_back(cyc);
            if (done) begin
                q_done.push_back(cyc);
`ifdef SIW_ADDRGEN_ABORT_EN
                done_beats = beats;
`endif
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] b, input logic [AW-1:0] st, input int k);
        int v;
        v = (int'(b) + k * int'(st)) % 1024;
        return AW'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic d, input logic [AW-1:0] b, input logic [AW-1:0] st,
                               input int n, input logic [1:0] cf, output int s);
        step();
        q_en.delete(); q_rv.delete(); q_we.delete(); q_done.delete(); q_init.delete();
        xfer_cyc.delete(); xfer_dat.delete();
        start = 1'b1; dir = d; base = b; stride = st; count = CW'(n); conf = cf;
        s = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (q_done.size() == 0 && n < bound) begin
            step();
            n++;
        end
        step();
        step();
    endtask

    task automatic do_write(input string tg, input logic [AW-1:0] b, input logic [AW-1:0] st,
                            input int n, input logic [1:0] cf, input bit rnd_gap, input int gap_at,
                            input bit poke, input int abort_after, input int exp_n);
        int s, idx, guard, gap_left, abort_c, done_exp, m;
        start_burst(1'b1, b, st, n, cf, s);
        idx = 0; guard = 0; gap_left = 2; abort_c = -1;
        while (idx < n && guard < 400) begin
            wvalid = 1'b1;
            if (rnd_gap && $urandom_range(0, 3) == 0) wvalid = 1'b0;
            if (idx == gap_at && gap_left > 0) begin
                wvalid = 1'b0;
                gap_left--;
            end
            wdata = $urandom;
            start = poke && (guard == 2);
            if (start) begin
                dir = 1'b0; base = AW'(5); count = CW'(1);
            end
`ifdef SIW_ADDRGEN_ABORT_EN
            if (abort_after >= 0 && idx == abort_after) begin
                abort = 1'b1;
                abort_c = cyc;
            end
`endif
            @(negedge clk);
            if (wvalid && wready) begin
                xfer_cyc.push_back(cyc);
                xfer_dat.push_back(wdata);
                idx++;
            end
            step();
            guard++;
`ifdef SIW_ADDRGEN_ABORT_EN
            abort = 1'b0;
`endif
            if (abort_c >= 0) break;
        end
        wvalid = 1'b0;
        start = 1'b0;
        wait_done(60);

        if (n == 0) done_exp = s + 2;
        else if (abort_c >= 0) done_exp = abort_c + 1 + int'(cf);
        else if (xfer_cyc.size() > 0) done_exp = xfer_cyc[xfer_cyc.size()-1] + int'(cf) + 1;
        else done_exp = -1;

        chk({tg, "_nbeats"}, 64'(xfer_cyc.size()), 64'(exp_n));
        chk({tg, "_nstrobes"}, 64'(q_we.size()), 64'(exp_n));
        chk({tg, "_nenables"}, 64'(q_en.size()), 64'(exp_n));
        m = (q_we.size() < xfer_cyc.size()) ? q_we.size() : xfer_cyc.size();
        for (int k = 0; k < m; k++) chk({tg, "_strobe_cyc"}, 64'(q_we[k]), 64'(xfer_cyc[k]));
        m = (q_en.size() < xfer_cyc.size()) ? q_en.size() : xfer_cyc.size();
        for (int k = 0; k < m; k++) begin
            chk({tg, "_en_cyc"}, 64'(q_en[k].c), 64'(xfer_cyc[k] + int'(cf)));
            chk({tg, "_addr"}, 64'(q_en[k].a), 64'(beat_addr(b, st, k)));
            chk({tg, "_wdata"}, 64'(q_en[k].d), 64'(xfer_dat[k]));
        end
        chk({tg, "_ndone"}, 64'(q_done.size()), 64'd1);
        if (q_done.size() > 0) chk({tg, "_done_cyc"}, 64'(q_done[0]), 64'(done_exp));
        chk({tg, "_ninit"}, 64'(q_init.size()), 64'd1);
        if (q_init.size() > 0) chk({tg, "_init_cyc"}, 64'(q_init[0]), 64'(s + 1));
        chk({tg, "_mem_conf"}, 64'(mem_conf), 64'(cf));
        chk({tg, "_busy_end"}, 64'(busy), 64'd0);
        for (int k = 0; k < xfer_dat.size(); k++) ref_mem[beat_addr(b, st, k)] = xfer_dat[k];
    endtask

    task automatic do_read(input string tg, input logic [AW-1:0] b, input logic [AW-1:0] st, input int n);
        int s, m;
        start_burst(1'b0, b, st, n, 2'd0, s);
        wait_done(n + 40);
        chk({tg, "_nenables"}, 64'(q_en.size()), 64'(n));
        chk({tg, "_nrvalid"}, 64'(q_rv.size()), 64'(n));
        chk({tg, "_nstrobes"}, 64'(q_we.size()), 64'd0);
        m = (q_en.size() < n) ? q_en.size() : n;
        for (int k = 0; k < m; k++) begin
            chk({tg, "_en_cyc"}, 64'(q_en[k].c), 64'(s + 1 + k));
            chk({tg, "_addr"}, 64'(q_en[k].a), 64'(beat_addr(b, st, k)));
        end
        m = (q_rv.size() < n) ? q_rv.size() : n;
        for (int k = 0; k < m; k++) begin
            chk({tg, "_rv_cyc"}, 64'(q_rv[k].c), 64'(s + 3 + k));
            chk({tg, "_rdata"}, 64'(q_rv[k].d), 64'(ref_mem[beat_addr(b, st, k)]));
        end
        chk({tg, "_ndone"}, 64'(q_done.size()), 64'd1);
        if (q_done.size() > 0) chk({tg, "_done_cyc"}, 64'(q_done[0]), 64'(n == 0 ? s + 2 : s + n + 3));
        chk({tg, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int s;
        logic [AW-1:0] rb, rs;
        int rn;
        logic [1:0] rc;

        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        preload = 1'b1;
        step();
        preload = 1'b0;
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mem_enable", 64'(mem_enable), 64'd0);
        chk("rst_mem_write_en", 64'(mem_write_en), 64'd0);
        chk("rst_mem_init", 64'(mem_init), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_conf", 64'(mem_conf), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        rst_n = 1'b1;
        step();

        // wrap across the top of the address space, no delay
        do_write("t1", AW'(10'h3FE), AW'(1), 4, 2'd0, 1'b0, -1, 1'b0, -1, 4);
        // maximum strobe delay, then read back
        do_write("t2", AW'(10'h155), AW'(7), 3, 2'd3, 1'b0, -1, 1'b0, -1, 3);
        do_read("t2rd", AW'(10'h155), AW'(7), 3);
        // strided read of preloaded contents
        do_read("t3", AW'(10'h010), AW'(4), 3);
        // two-cycle wvalid gap plus an ignored start
        do_write("t4", AW'(10'h200), AW'(3), 6, 2'd1, 1'b0, 2, 1'b1, -1, 6);
        do_read("t4rd", AW'(10'h200), AW'(3), 6);
        // empty bursts
        do_read("t5rd0", AW'(10'h040), AW'(1), 0);
        do_write("t5wr0", AW'(10'h040), AW'(1), 0, 2'd2, 1'b0, -1, 1'b0, -1, 0);

        // reset in the middle of a read burst
        start_burst(1'b0, AW'(10'h080), AW'(1), 20, 2'd1, s);
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_mem_enable", 64'(mem_enable), 64'd0);
        chk("mrst_mem_addr", 64'(mem_addr), 64'd0);
        chk("mrst_mem_conf", 64'(mem_conf), 64'd0);
        chk("mrst_rvalid", 64'(rvalid), 64'd0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("mrst_no_done", 64'(q_done.size()), 64'd0);
        chk("mrst_idle_enable", 64'(mem_enable), 64'd0);

        for (int it = 0; it < 4; it++) begin
            rb = AW'($urandom);
            rs = AW'($urandom_range(0, 1023));
            rn = $urandom_range(1, 12);
            rc = 2'($urandom_range(0, 3));
            do_write("rnd_wr", rb, rs, rn, rc, 1'b1, -1, 1'b0, -1, rn);
            do_read("rnd_rd", rb, rs, rn);
        end

`ifdef SIW_ADDRGEN_ABORT_EN
        do_write("abort", AW'(10'h300), AW'(1), 8, 2'd1, 1'b0, -1, 1'b0, 3, 3);
        chk("abort_beats", 64'(done_beats), 64'd3);
        do_read("abort_rd", AW'(10'h300), AW'(1), 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
